// File: rtl/ap_ctrl_pkg.sv
// Shared types and constants for the HLS block-level handshake driver.
// The optional ap_continue backpressure is enabled by defining AP_CONTINUE_STALL_EN.
package ap_ctrl_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} ap_drv_state_t;

   localparam int CNT_W_DEF           = 32;
   localparam int MAX_OUTSTANDING_DEF = 1;
   localparam int STALL_CYCLES_DEF    = 3;

   localparam int ERR_SPURIOUS_DONE  = 0;
   localparam int ERR_READY_NO_START = 1;
   localparam int ERR_NOT_IDLE       = 2;
   localparam int ERR_W              = 3;

endpackage

// File: rtl/ap_continue_staller.sv
// Drops ap_continue for STALL_CYCLES cycles after every retired completion.
// Only instantiated when AP_CONTINUE_STALL_EN is defined.
module ap_continue_staller
   import ap_ctrl_pkg::*;
#(
   parameter int STALL_CYCLES = STALL_CYCLES_DEF
) (
   input  logic clock,
   input  logic reset,
   input  logic retire,
   output logic ap_continue
);

   localparam int SW = (STALL_CYCLES > 0) ? $clog2(STALL_CYCLES + 1) : 1;

   logic [SW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (retire) begin
         cnt_d = SW'(STALL_CYCLES);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - SW'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign ap_continue = (cnt_q == '0);

endmodule

// File: rtl/ap_ctrl_driver.sv
// Active initiator for the HLS ap_start/ap_ready/ap_done/ap_continue handshake.
// Define AP_CONTINUE_STALL_EN to model downstream backpressure on ap_continue.
module ap_ctrl_driver
   import ap_ctrl_pkg::*;
#(
   parameter int CNT_W           = CNT_W_DEF,
   parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
`ifdef AP_CONTINUE_STALL_EN
   ,
   parameter int STALL_CYCLES    = STALL_CYCLES_DEF
`endif
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             go,
   input  logic [CNT_W-1:0] trans_count,
   output logic             ap_start,
   input  logic             ap_ready,
   input  logic             ap_done,
   input  logic             ap_idle,
   output logic             ap_continue,
   output logic             busy,
   output logic             finish,
   output logic [CNT_W-1:0] started_cnt,
   output logic [CNT_W-1:0] done_cnt,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic             err
);

   localparam logic [CNT_W-1:0] One    = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] MaxOut = CNT_W'(MAX_OUTSTANDING);

   ap_drv_state_t    state_q, state_d;
   logic [CNT_W-1:0] tc_q, tc_d;
   logic [CNT_W-1:0] started_q, started_d, started_nx;
   logic [CNT_W-1:0] done_q, done_d, done_nx;
   logic [CNT_W-1:0] cycle_q, cycle_d;
   logic [ERR_W-1:0] err_q, err_d, err_set;
   logic             finish_q, finish_d;
   logic             ap_start_q, ap_start_d;
   logic             busy_w, start_hs, retire;

   always_comb begin
      busy_w     = (state_q == RUN) || (state_q == DRAIN);
      start_hs   = ap_start_q && ap_ready;
      retire     = busy_w && ap_done && ap_continue;
      started_nx = started_q + (start_hs ? One : '0);
      done_nx    = done_q + (retire ? One : '0);
      err_set    = '0;
      err_set[ERR_SPURIOUS_DONE]  = ap_done && (started_q == done_q) && !start_hs;
      err_set[ERR_READY_NO_START] = ap_ready && !ap_start_q;
      err_set[ERR_NOT_IDLE]       = (state_q == FINISH) && !ap_idle;
   end

   // An accepted go reloads everything, so a restart from FINISH looks like one from IDLE.
   always_comb begin
      state_d   = state_q;
      tc_d      = tc_q;
      started_d = started_nx;
      done_d    = done_nx;
      cycle_d   = (busy_w && (cycle_q != '1)) ? cycle_q + One : cycle_q;
      finish_d  = finish_q;
      err_d     = err_q | err_set;
      case (state_q)
         IDLE, FINISH: begin
            if (go) begin
               tc_d      = trans_count;
               started_d = '0;
               done_d    = '0;
               cycle_d   = '0;
               err_d     = '0;
               if (trans_count == '0) begin
                  state_d  = FINISH;
                  finish_d = 1'b1;
               end else begin
                  state_d  = RUN;
                  finish_d = 1'b0;
               end
            end
         end
         RUN: begin
            if (started_nx == tc_q) state_d = DRAIN;
         end
         DRAIN: begin
            if (done_nx == tc_q) begin
               state_d  = FINISH;
               finish_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      // Evaluated on the state being entered, so the first start is presented right after go.
      ap_start_d = (state_d == RUN) && (started_d < tc_d) && ((started_d - done_d) < MaxOut);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         tc_q       <= '0;
         started_q  <= '0;
         done_q     <= '0;
         cycle_q    <= '0;
         err_q      <= '0;
         finish_q   <= 1'b0;
         ap_start_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         tc_q       <= tc_d;
         started_q  <= started_d;
         done_q     <= done_d;
         cycle_q    <= cycle_d;
         err_q      <= err_d;
         finish_q   <= finish_d;
         ap_start_q <= ap_start_d;
      end
   end

`ifdef AP_CONTINUE_STALL_EN
   ap_continue_staller #(
      .STALL_CYCLES(STALL_CYCLES)
   ) u_staller (
      .clock       (clock),
      .reset       (reset),
      .retire      (retire),
      .ap_continue (ap_continue)
   );
`else
   assign ap_continue = 1'b1;
`endif

   assign ap_start    = ap_start_q;
   assign busy        = busy_w;
   assign finish      = finish_q;
   assign started_cnt = started_q;
   assign done_cnt    = done_q;
   assign cycle_cnt   = cycle_q;
   assign err         = |err_q;

endmodule

// File: tb/tb_ap_ctrl_driver.sv
// Directed bench for ap_ctrl_driver: a serial instance (MAX_OUTSTANDING=1, ready immediate,
// 4 idle cycles to done) and a pipelined one (MAX_OUTSTANDING=2, ready after 2 cycles, 6 idle cycles).
module tb_ap_ctrl_driver;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        go          [2];
   logic [31:0] tcnt        [2];
   logic        ap_start    [2];
   logic        ap_ready    [2];
   logic        ap_done     [2];
   logic        ap_idle     [2];
   logic        ap_continue [2];
   logic        busy        [2];
   logic        finish      [2];
   logic [31:0] started_cnt [2];
   logic [31:0] done_cnt    [2];
   logic [31:0] cycle_cnt   [2];
   logic        err         [2];

   logic m_rdy [2], m_done [2], m_idle [2];
   logic inj_done [2], inj_rdy [2], inj_nidle [2];
   int   lat     [2] = '{4, 6};
   int   rdy_dly [2] = '{0, 2};
   int   waitc   [2];
   int   due     [2][4];
   int   due_n   [2];
   int   cyc;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   for (genvar g = 0; g < 2; g++) begin : g_in
      assign ap_ready[g] = m_rdy[g] | inj_rdy[g];
      assign ap_done[g]  = m_done[g] | inj_done[g];
      assign ap_idle[g]  = m_idle[g] & ~inj_nidle[g];
   end

   ap_ctrl_driver #(.CNT_W(32), .MAX_OUTSTANDING(1)) u_ser (
      .clock(clock), .reset(reset), .go(go[0]), .trans_count(tcnt[0]),
      .ap_start(ap_start[0]), .ap_ready(ap_ready[0]), .ap_done(ap_done[0]), .ap_idle(ap_idle[0]),
      .ap_continue(ap_continue[0]), .busy(busy[0]), .finish(finish[0]),
      .started_cnt(started_cnt[0]), .done_cnt(done_cnt[0]), .cycle_cnt(cycle_cnt[0]), .err(err[0])
   );

   ap_ctrl_driver #(.CNT_W(32), .MAX_OUTSTANDING(2)) u_pipe (
      .clock(clock), .reset(reset), .go(go[1]), .trans_count(tcnt[1]),
      .ap_start(ap_start[1]), .ap_ready(ap_ready[1]), .ap_done(ap_done[1]), .ap_idle(ap_idle[1]),
      .ap_continue(ap_continue[1]), .busy(busy[1]), .finish(finish[1]),
      .started_cnt(started_cnt[1]), .done_cnt(done_cnt[1]), .cycle_cnt(cycle_cnt[1]), .err(err[1])
   );

   // Behavioural HLS block: ready after rdy_dly waiting cycles, done lat idle cycles after the
   // start handshake, ap_done held until ap_continue (ap_ctrl_chain style).
   initial begin
      for (int k = 0; k < 2; k++) begin
         m_rdy[k] = 1'b0; m_done[k] = 1'b0; m_idle[k] = 1'b1; waitc[k] = 0; due_n[k] = 0;
      end
      cyc = 0;
      forever begin
         @(negedge clock);
         if (reset) begin
            for (int k = 0; k < 2; k++) begin
               m_rdy[k] = 1'b0; m_done[k] = 1'b0; m_idle[k] = 1'b1; waitc[k] = 0; due_n[k] = 0;
            end
         end else begin
            cyc++;
            for (int k = 0; k < 2; k++) begin
               m_idle[k] = (due_n[k] == 0) && !ap_start[k];
               m_rdy[k]  = ap_start[k] && (waitc[k] >= rdy_dly[k]);
               if (m_rdy[k]) begin
                  due[k][due_n[k]] = cyc + lat[k] + 1;
                  due_n[k]++;
                  waitc[k] = 0;
               end else if (ap_start[k]) begin
                  waitc[k]++;
               end
               m_done[k] = (due_n[k] > 0) && (due[k][0] <= cyc);
               if (m_done[k] && ap_continue[k]) begin
                  for (int j = 0; j < 3; j++) due[k][j] = due[k][j+1];
                  due_n[k]--;
               end
            end
         end
      end
   end

   task automatic pulse_go(input int k, input logic [31:0] tc);
      @(negedge clock);
      go[k]   = 1'b1;
      tcnt[k] = tc;
      @(negedge clock);
      go[k]   = 1'b0;
      #1;
   endtask

   task automatic wait_finish(input int k, input int budget, output int n);
      n = 0;
      while (finish[k] !== 1'b1 && n < budget) begin
         @(negedge clock); #1;
         n++;
      end
      n_checks++;
      if (finish[k] !== 1'b1) begin
         n_fail++;
         $display("FAIL finish_timeout[%0d]: finish=%b after %0d cycles, required 1", k, finish[k], n);
      end
   endtask

   task automatic test_reset();
      #1;
      for (int k = 0; k < 2; k++) begin
         n_checks++;
         if ({ap_start[k], busy[k], finish[k], err[k], ap_continue[k]} !== 5'b00001) begin
            n_fail++;
            $display("FAIL reset_flags[%0d]: start,busy,finish,err,cont=%b required 00001", k,
                     {ap_start[k], busy[k], finish[k], err[k], ap_continue[k]});
         end
         n_checks++;
         if ({started_cnt[k], done_cnt[k], cycle_cnt[k]} !== 96'd0) begin
            n_fail++;
            $display("FAIL reset_counters[%0d]: %0d/%0d/%0d required 0/0/0", k,
                     started_cnt[k], done_cnt[k], cycle_cnt[k]);
         end
      end
      repeat (2) @(negedge clock);
      #2 reset = 1'b0;
   endtask

   task automatic test_serial();
      int n;
      int maxo;
      pulse_go(0, 32'd3);
      pulse_go(0, 32'd7);
      n = 0;
      maxo = 0;
      while (finish[0] !== 1'b1 && n < 200) begin
         @(negedge clock); #1;
         n++;
         if (int'(started_cnt[0] - done_cnt[0]) > maxo) maxo = int'(started_cnt[0] - done_cnt[0]);
      end
      n_checks++;
      if (n !== 16) begin n_fail++; $display("FAIL serial_finish_time: %0d cycles, required 16", n); end
      n_checks++;
      if (maxo !== 1) begin n_fail++; $display("FAIL serial_outstanding: max %0d, required 1", maxo); end
      n_checks++;
      if (started_cnt[0] !== 32'd3 || done_cnt[0] !== 32'd3) begin
         n_fail++;
         $display("FAIL serial_counts: started=%0d done=%0d, required 3/3", started_cnt[0], done_cnt[0]);
      end
      n_checks++;
      if (cycle_cnt[0] !== 32'd18) begin n_fail++; $display("FAIL serial_cycles: %0d, required 18", cycle_cnt[0]); end
      n_checks++;
      if ({err[0], busy[0], ap_start[0]} !== 3'b000) begin
         n_fail++;
         $display("FAIL serial_end_flags: err,busy,start=%b required 000", {err[0], busy[0], ap_start[0]});
      end
   endtask

   task automatic test_zero();
      int starts;
      pulse_go(0, 32'd0);
      n_checks++;
      if ({finish[0], busy[0], ap_start[0]} !== 3'b100) begin
         n_fail++;
         $display("FAIL zero_flags: finish,busy,start=%b required 100", {finish[0], busy[0], ap_start[0]});
      end
      n_checks++;
      if ({started_cnt[0], done_cnt[0], cycle_cnt[0]} !== 96'd0) begin
         n_fail++;
         $display("FAIL zero_counters: %0d/%0d/%0d required 0/0/0", started_cnt[0], done_cnt[0], cycle_cnt[0]);
      end
      starts = 0;
      repeat (4) begin
         @(negedge clock); #1;
         if (ap_start[0] === 1'b1) starts++;
      end
      n_checks++;
      if (starts !== 0 || finish[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL zero_hold: start cycles=%0d finish=%b, required 0 and 1", starts, finish[0]);
      end
   endtask

   task automatic test_protocol_errors();
      int n;
      for (int c = 0; c < 3; c++) begin
         @(negedge clock);
         inj_done[0] = (c == 0); inj_rdy[0] = (c == 1); inj_nidle[0] = (c == 2);
         @(negedge clock);
         inj_done[0] = 1'b0; inj_rdy[0] = 1'b0; inj_nidle[0] = 1'b0;
         #1;
         n_checks++;
         if (err[0] !== 1'b1) begin n_fail++; $display("FAIL err_set_cause%0d: err=%b required 1", c, err[0]); end
         repeat (3) @(negedge clock);
         #1;
         n_checks++;
         if (err[0] !== 1'b1) begin n_fail++; $display("FAIL err_sticky_cause%0d: err=%b required 1", c, err[0]); end
         pulse_go(0, 32'd1);
         n_checks++;
         if (err[0] !== 1'b0) begin n_fail++; $display("FAIL err_clear_cause%0d: err=%b required 0", c, err[0]); end
         wait_finish(0, 50, n);
         n_checks++;
         if (err[0] !== 1'b0 || done_cnt[0] !== 32'd1) begin
            n_fail++;
            $display("FAIL err_rerun_cause%0d: err=%b done=%0d required 0/1", c, err[0], done_cnt[0]);
         end
      end
   endtask

   task automatic test_reset_mid_run();
      int n;
      pulse_go(0, 32'd2);
      n = 0;
      while (!(busy[0] === 1'b1 && started_cnt[0] === 32'd2 && done_cnt[0] === 32'd1) && n < 50) begin
         @(negedge clock); #1;
         n++;
      end
      n_checks++;
      if (done_cnt[0] !== 32'd1 || started_cnt[0] !== 32'd2) begin
         n_fail++;
         $display("FAIL midrun_reach_drain: started=%0d done=%0d required 2/1", started_cnt[0], done_cnt[0]);
      end
      reset = 1'b1;
      #1;
      n_checks++;
      if ({ap_start[0], busy[0], finish[0], err[0], ap_continue[0]} !== 5'b00001) begin
         n_fail++;
         $display("FAIL midrun_async_flags: start,busy,finish,err,cont=%b required 00001",
                  {ap_start[0], busy[0], finish[0], err[0], ap_continue[0]});
      end
      n_checks++;
      if ({started_cnt[0], done_cnt[0], cycle_cnt[0]} !== 96'd0) begin
         n_fail++;
         $display("FAIL midrun_async_counters: %0d/%0d/%0d required 0/0/0",
                  started_cnt[0], done_cnt[0], cycle_cnt[0]);
      end
      @(negedge clock);
      @(negedge clock);
      #2 reset = 1'b0;
      @(negedge clock); #1;
      n_checks++;
      if (finish[0] !== 1'b0) begin n_fail++; $display("FAIL midrun_no_finish: finish=%b required 0", finish[0]); end
      pulse_go(0, 32'd2);
      wait_finish(0, 100, n);
      n_checks++;
      if (n !== 12 || cycle_cnt[0] !== 32'd12) begin
         n_fail++;
         $display("FAIL midrun_rerun_time: wait=%0d cycle_cnt=%0d required 12/12", n, cycle_cnt[0]);
      end
      n_checks++;
      if (started_cnt[0] !== 32'd2 || done_cnt[0] !== 32'd2 || err[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL midrun_rerun_counts: started=%0d done=%0d err=%b required 2/2/0",
                  started_cnt[0], done_cnt[0], err[0]);
      end
   endtask

   task automatic test_pipelined();
      int n, maxo, viol, waits, cont_low;
      logic prev_s, prev_r;
      pulse_go(1, 32'd4);
      n = 0; maxo = 0; viol = 0; waits = 0; cont_low = 0;
      prev_s = 1'b0; prev_r = 1'b0;
      while (n < 200) begin
         if (int'(started_cnt[1] - done_cnt[1]) > maxo) maxo = int'(started_cnt[1] - done_cnt[1]);
         if (prev_s && !prev_r && ap_start[1] !== 1'b1) viol++;
         if (ap_start[1] === 1'b1 && ap_ready[1] !== 1'b1) waits++;
         if (ap_continue[1] !== 1'b1) cont_low++;
         prev_s = ap_start[1];
         prev_r = ap_ready[1];
         if (finish[1] === 1'b1) break;
         @(negedge clock); #1;
         n++;
      end
      n_checks++;
      if (finish[1] !== 1'b1) begin n_fail++; $display("FAIL pipe_finish: finish=%b required 1", finish[1]); end
      n_checks++;
      if (maxo !== 2) begin n_fail++; $display("FAIL pipe_outstanding: max %0d, required 2", maxo); end
      n_checks++;
      if (viol !== 0 || waits !== 8) begin
         n_fail++;
         $display("FAIL pipe_start_hold: early drops=%0d wait cycles=%0d required 0/8", viol, waits);
      end
      n_checks++;
      if (started_cnt[1] !== 32'd4 || done_cnt[1] !== 32'd4 || err[1] !== 1'b0) begin
         n_fail++;
         $display("FAIL pipe_counts: started=%0d done=%0d err=%b required 4/4/0",
                  started_cnt[1], done_cnt[1], err[1]);
      end
`ifndef AP_CONTINUE_STALL_EN
      n_checks++;
      if (cycle_cnt[1] !== 32'd23 || cont_low !== 0) begin
         n_fail++;
         $display("FAIL pipe_cycles: cycle_cnt=%0d continue-low cycles=%0d required 23/0", cycle_cnt[1], cont_low);
      end
`endif
   endtask

`ifdef AP_CONTINUE_STALL_EN
   task automatic test_stall();
      int n, post, lowlen, runs, ret;
      pulse_go(1, 32'd4);
      n = 0; post = 0; lowlen = 0; runs = 0; ret = 0;
      while (n < 300 && post < 5) begin
         if (ap_continue[1] !== 1'b1) begin
            lowlen++;
         end else if (lowlen != 0) begin
            n_checks++;
            if (lowlen !== 3) begin n_fail++; $display("FAIL stall_len: low for %0d cycles, required 3", lowlen); end
            lowlen = 0;
            runs++;
         end
         if (busy[1] === 1'b1 && ap_done[1] === 1'b1 && ap_continue[1] === 1'b1) ret++;
         if (finish[1] === 1'b1) post++;
         @(negedge clock); #1;
         n++;
      end
      n_checks++;
      if (runs !== 4 || ret !== 4 || done_cnt[1] !== 32'd4) begin
         n_fail++;
         $display("FAIL stall_counts: low runs=%0d retires=%0d done=%0d required 4/4/4", runs, ret, done_cnt[1]);
      end
      n_checks++;
      if (finish[1] !== 1'b1 || ap_continue[1] !== 1'b1 || err[1] !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_end: finish=%b cont=%b err=%b required 1/1/0", finish[1], ap_continue[1], err[1]);
      end
   endtask
`endif

   initial begin
      for (int k = 0; k < 2; k++) begin
         go[k] = 1'b0; tcnt[k] = '0;
         inj_done[k] = 1'b0; inj_rdy[k] = 1'b0; inj_nidle[k] = 1'b0;
      end
      test_reset();
      test_serial();
      test_zero();
      test_protocol_errors();
      test_reset_mid_run();
      test_pipelined();
`ifdef AP_CONTINUE_STALL_EN
      test_stall();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ap_ctrl_driver.md
Name: ap_ctrl_driver

Overview:
- Active initiator for the HLS block-level handshake (ap_start/ap_ready/ap_done/ap_idle/ap_continue) in the co-simulation harness.
- Issues a programmed number of transactions into the DUT, with overlap limited by an outstanding bound.
- Counts issued and completed transactions and measures total run cycles.
- Raises finish once the last ap_done retires; the dataflow/status monitors consume this finish.

Parameters:
- CNT_W, 32, width of all counters and trans_count.
- MAX_OUTSTANDING, 1, maximum started-but-not-done transactions (1 = strictly serial; >1 allows pipelined restarts).
- STALL_CYCLES, 3, ap_continue low-time per completion; used only with AP_CONTINUE_STALL_EN.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- go  in  1  single-cycle pulse that starts a run; ignored unless state is IDLE or FINISH.
- trans_count  in  CNT_W  number of transactions; sampled on the accepted go.
- ap_start  out  1  DUT start request.
- ap_ready  in  1  DUT accepted the current start.
- ap_done  in  1  DUT completed a transaction.
- ap_idle  in  1  DUT idle; only checked in FINISH.
- ap_continue  out  1  permission to retire ap_done.
- busy  out  1  high in RUN or DRAIN.
- finish  out  1  run complete; held until the next go or reset.
- started_cnt  out  CNT_W  completed start handshakes.
- done_cnt  out  CNT_W  retired completions.
- cycle_cnt  out  CNT_W  cycles spent in RUN plus DRAIN.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (async, active-high): state=IDLE. All outputs 0 except ap_continue=1. Counters cleared. A reset mid-run aborts immediately; no finish pulse is produced.
- Start handshake: completes in any cycle with ap_start && ap_ready, and increments started_cnt.
- Completion: retires in any cycle with ap_done && ap_continue, and increments done_cnt.
- Same-cycle start and completion: both counted; outstanding is unchanged.
- outstanding = started_cnt - done_cnt, computed at CNT_W bits.
- ap_start is registered. Next value = (state==RUN) && (started_next < tc_q) && (started_next - done_next < MAX_OUTSTANDING), where started_next and done_next include this cycle's events.
  - Once asserted, ap_start is held until ap_ready; it never drops before ap_ready.
  - Back-to-back starts are allowed when the limits permit.
- States:
  - IDLE --go--> RUN. On this transition: tc_q=trans_count, counters cleared, finish=0. If trans_count==0, go to FINISH instead, setting finish=1 on the next edge.
  - RUN --(started_next==tc_q)--> DRAIN.
  - DRAIN --(done_next==tc_q)--> FINISH, setting finish=1 on the same edge.
  - FINISH --go--> RUN, with the same load as from IDLE.
- cycle_cnt increments every cycle in RUN or DRAIN.
  - It saturates at all-ones.
  - Serial example with MAX_OUTSTANDING=1, a DUT with a 1-cycle start handshake, and fixed latency L: cycle_cnt = N*(L+2).
- err is set (sticky until reset or accepted go) when any of these occurs:
  - ap_done with outstanding==0 and no same-cycle start handshake;
  - ap_ready while ap_start==0;
  - ap_idle==0 observed in FINISH.
- go while busy: ignored, no error.
- Counter wrap: trans_count is at most 2^CNT_W-1, so counters never wrap within a run.

Optional Feature:
- Macro: AP_CONTINUE_STALL_EN.
- Defined: after each retired completion, ap_continue drops to 0 for STALL_CYCLES cycles, then returns to 1. ap_done held by an ap_ctrl_chain DUT during that window is not counted until ap_continue returns to 1. This models downstream backpressure.
- Undefined: ap_continue is tied to 1; the stall counter and its logic are absent.

Decomposition:
- Shared package ap_ctrl_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} ap_drv_state_t;
  - localparam defaults for CNT_W and MAX_OUTSTANDING;
  - error-cause bit indices.
- One natural sub-module: ap_continue_staller, holding the stall counter and ap_continue generation. It is instantiated only under AP_CONTINUE_STALL_EN.

Test Plan:
- Serial run: trans_count=3, MAX_OUTSTANDING=1, DUT with immediate ap_ready and done after 4 cycles -> 3 non-overlapping starts; started_cnt=done_cnt=3; finish high on the edge after the 3rd ap_done; cycle_cnt=18; err=0.
- Pipelined run: MAX_OUTSTANDING=2, trans_count=4, ap_ready delayed 2 cycles, latency 6 -> outstanding never exceeds 2; ap_start held steadily through the ap_ready delay; done_cnt=4; finish=1.
- Zero-transaction run: go with trans_count=0 -> finish=1 one cycle later; ap_start never asserted; all counters 0.
- Protocol error: spurious ap_done with outstanding=0 -> err=1 and stays 1; the next go clears it.
- Reset mid-run: assert reset during DRAIN with done_cnt=1 -> all outputs return to reset values asynchronously; finish stays 0; a subsequent go with trans_count=2 completes normally.
- With AP_CONTINUE_STALL_EN and STALL_CYCLES=3, DUT holding ap_done until ap_continue -> ap_continue low for 3 cycles after each retirement; each ap_done is counted exactly once.
